// File: rtl/mem_arbiter.sv
// Two-port arbiter sequencing a single strobe-driven memory between instruction fetch and data port.
// Define MEM_ARB_RR_EN for round-robin tie-breaking; otherwise the data port always wins ties.
`timescale 1ns/1ps

module mem_arbiter #(
    parameter int AWIDTH        = 15,
    parameter int DWIDTH        = 11,
    parameter int STROBE_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [AWIDTH-1:0] if_addr,
    output logic              if_ack,
    output logic [DWIDTH-1:0] if_rdata,
    input  logic              dp_req,
    input  logic              dp_we,
    input  logic [AWIDTH-1:0] dp_addr,
    input  logic [DWIDTH-1:0] dp_wdata,
    output logic              dp_ack,
    output logic [DWIDTH-1:0] dp_rdata,
    output logic              mem_wr,
    output logic              mem_rd,
    output logic [AWIDTH-1:0] mem_addr,
    output logic [DWIDTH-1:0] mem_wdata,
    input  logic [DWIDTH-1:0] mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, ACCESS, RELEASE} state_t;
    typedef enum logic {OWN_IF = 1'b0, OWN_DP = 1'b1} owner_t;

    localparam logic [3:0] CNT_INIT = 4'(STROBE_CYCLES - 1);

    state_t            state, state_nxt;
    owner_t            owner, owner_nxt;
    logic [3:0]        cnt, cnt_nxt;
    logic              mem_wr_nxt, mem_rd_nxt, if_ack_nxt, dp_ack_nxt;
    logic [AWIDTH-1:0] mem_addr_nxt;
    logic [DWIDTH-1:0] mem_wdata_nxt, if_rdata_nxt, dp_rdata_nxt;
    logic              grant_dp;

`ifdef MEM_ARB_RR_EN
    owner_t last, last_nxt;

    // On a tie, serve whichever port was not granted most recently.
    assign grant_dp = dp_req && (!if_req || (last == OWN_IF));
`else
    assign grant_dp = dp_req;
`endif

    // NOTE: every next-state variable gets a default first, so no path through the case infers a latch.
    always_comb begin
        state_nxt     = state;
        owner_nxt     = owner;
        cnt_nxt       = cnt;
        mem_wr_nxt    = mem_wr;
        mem_rd_nxt    = mem_rd;
        mem_addr_nxt  = mem_addr;
        mem_wdata_nxt = mem_wdata;
        if_rdata_nxt  = if_rdata;
        dp_rdata_nxt  = dp_rdata;
        if_ack_nxt    = 1'b0;
        dp_ack_nxt    = 1'b0;
`ifdef MEM_ARB_RR_EN
        last_nxt      = last;
`endif
        unique case (state)
            IDLE: begin
                if (if_req || dp_req) begin
                    owner_nxt = grant_dp ? OWN_DP : OWN_IF;
                    if (grant_dp) begin
                        mem_addr_nxt  = dp_addr;
                        mem_wdata_nxt = dp_wdata;
                    end else begin
                        mem_addr_nxt  = if_addr;
                    end
                    mem_wr_nxt = grant_dp && dp_we;
                    mem_rd_nxt = !(grant_dp && dp_we);
                    cnt_nxt    = CNT_INIT;
                    state_nxt  = ACCESS;
`ifdef MEM_ARB_RR_EN
                    last_nxt   = grant_dp ? OWN_DP : OWN_IF;
`endif
                end
            end
            ACCESS: begin
                if (cnt == 4'd0) begin
                    mem_wr_nxt = 1'b0;
                    mem_rd_nxt = 1'b0;
                    if (owner == OWN_DP) begin
                        dp_ack_nxt = 1'b1;
                        if (mem_rd) dp_rdata_nxt = mem_rdata;
                    end else begin
                        if_ack_nxt   = 1'b1;
                        if_rdata_nxt = mem_rdata;
                    end
                    state_nxt = RELEASE;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            // Strobes low for one cycle while addr/wdata stay put to give the memory hold time.
            RELEASE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            owner     <= OWN_IF;
            cnt       <= 4'd0;
            mem_wr    <= 1'b0;
            mem_rd    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_rdata  <= '0;
            dp_rdata  <= '0;
            if_ack    <= 1'b0;
            dp_ack    <= 1'b0;
            busy      <= 1'b0;
`ifdef MEM_ARB_RR_EN
            last      <= OWN_IF;
`endif
        end else begin
            state     <= state_nxt;
            owner     <= owner_nxt;
            cnt       <= cnt_nxt;
            mem_wr    <= mem_wr_nxt;
            mem_rd    <= mem_rd_nxt;
            mem_addr  <= mem_addr_nxt;
            mem_wdata <= mem_wdata_nxt;
            if_rdata  <= if_rdata_nxt;
            dp_rdata  <= dp_rdata_nxt;
            if_ack    <= if_ack_nxt;
            dp_ack    <= dp_ack_nxt;
            busy      <= (state_nxt != IDLE);
`ifdef MEM_ARB_RR_EN
            last      <= last_nxt;
`endif
        end
    end

endmodule
